// File: rtl/conf_int_mul_pkg.sv
// Purpose : shared types, mode constants and the saturating product window for the pipelined multiplier.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a.
//
// Contents:
//   state_e         control FSM states (S_IDLE, S_RUN, S_FLUSH)
//   MODE_DIRECT     window LSB = OUT_LSB
//   MODE_PRESHIFT   A pre-shifted left, window LSB = OUT_LSB + PRESHIFT
//   sat_window      windowed, saturated value of a sign-extended product
//   window_ovf      1 when sat_window had to clamp
package conf_int_mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic MODE_DIRECT   = 1'b0;
  localparam logic MODE_PRESHIFT = 1'b1;

  // Products are carried sign-extended to this width into the window
  // functions, so the functions stay independent of the operand width.
  // Requires 2*DATA_PATH_BITWIDTH <= WIN_W.
  localparam int WIN_W = 64;

  // Largest positive value representable in k signed bits.
  function automatic logic signed [WIN_W-1:0] win_hi(input int unsigned k);
    return (64'sd1 <<< (k - 1)) - 64'sd1;
  endfunction

  // Arithmetic shift down to the window LSB, then clamp to k signed bits.
  // A value outside the k-bit range is exactly the case where the bits
  // above the window are not all copies of the window's top bit.
  function automatic logic signed [WIN_W-1:0] sat_window(
    input logic signed [WIN_W-1:0] prod,
    input int unsigned             lsb,
    input int unsigned             k
  );
    logic signed [WIN_W-1:0] sh;
    logic signed [WIN_W-1:0] hi;
    logic signed [WIN_W-1:0] lo;
    sh = prod >>> lsb;
    hi = win_hi(k);
    lo = ~hi;
    if (sh > hi) begin
      return hi;
    end else if (sh < lo) begin
      return lo;
    end
    return sh;
  endfunction

  function automatic logic window_ovf(
    input logic signed [WIN_W-1:0] prod,
    input int unsigned             lsb,
    input int unsigned             k
  );
    logic signed [WIN_W-1:0] sh;
    logic signed [WIN_W-1:0] hi;
    sh = prod >>> lsb;
    hi = win_hi(k);
    return (sh > hi) || (sh < ~hi);
  endfunction

endpackage

// File: rtl/conf_int_mul_core.sv
// Purpose : combinational signed DP x DP multiplier; isolated so an approximate core can be dropped in.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller holds the operands stable while stalled.
//
// Ports:
//   a_i  in  DP     signed operand A
//   b_i  in  DP     signed operand B
//   p_o  out 2*DP   full-precision signed product
module conf_int_mul_core #(
  parameter int DP = 24
) (
  input  logic signed [DP-1:0]   a_i,
  input  logic signed [DP-1:0]   b_i,
  output logic signed [2*DP-1:0] p_o
);

  assign p_o = (2*DP)'(a_i) * (2*DP)'(b_i);

endmodule

// File: rtl/conf_int_mul_pipe_wrapper.sv
// Purpose : pipelined configurable signed multiplier with A pre-shift, rapx truncation and saturating output window.
// Latency : PIPE_STAGES cycles from accept to out_valid while the output is not stalled.
// Backpr. : the whole pipeline freezes while out_valid & !out_ready; in_ready drops in the same cycle.
//
// Ports:
//   clk, racc (async high reset), rstP (sync clear, highest priority)
//   en, flush            run enable / stop-accepting-and-drain request
//   in_valid/in_ready    input handshake carrying a_in, b_in, mode, rapx
//   out_valid/out_ready  output handshake carrying p_out, ovf
//   flush_done           single-cycle pulse when a drain completes
//   sample_cnt           accepted samples since reset/flush/rstP, wraps
module conf_int_mul_pipe_wrapper
  import conf_int_mul_pkg::*;
#(
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int OUT_BITWIDTH       = 32,
  parameter int GUARD_BITS         = 3,
  parameter int OUT_LSB            = 11,
  parameter int PRESHIFT           = 8,
  parameter int APX_ZERO_BITS      = 8,
  parameter int PIPE_STAGES        = 2,
  parameter int CNT_BITWIDTH       = 9
) (
  input  logic                          clk,
  input  logic                          racc,
  input  logic                          rstP,
  input  logic                          rapx,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a_in,
  input  logic [DATA_PATH_BITWIDTH-1:0] b_in,
  input  logic                          mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_BITWIDTH-1:0]       p_out,
  output logic                          ovf,
  output logic                          flush_done,
  output logic [CNT_BITWIDTH-1:0]       sample_cnt
);

  localparam int DP   = DATA_PATH_BITWIDTH;
  localparam int NRES = PIPE_STAGES - 1;  // stage 2 plus plain delay stages
  localparam int unsigned K_U     = OUT_BITWIDTH - GUARD_BITS;
  localparam int unsigned LSB_DIR = OUT_LSB;
  localparam int unsigned LSB_PRE = OUT_LSB + PRESHIFT;
  localparam logic [DP-1:0] APX_MASK = {DP{1'b1}} << APX_ZERO_BITS;

  state_e state_q, state_d;
  logic   adv_c, accept_c, any_vld_c, flush_done_c;

  logic          s1_vld_q, s1_mode_q;
  logic [DP-1:0] s1_a_q, s1_b_q;
  logic [DP-1:0] a_eff_c, b_eff_c;

  logic signed [2*DP-1:0]  prod_c;
  logic signed [WIN_W-1:0] prod_w_c;
  int unsigned             lsb_c;
  logic [OUT_BITWIDTH-1:0] res_dat_c;
  logic                    res_ovf_c;

  logic [NRES-1:0]         res_vld_q;
  logic [NRES-1:0]         res_ovf_q;
  logic [OUT_BITWIDTH-1:0] res_dat_q [NRES];

  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;

  // Handshake
  assign out_valid = res_vld_q[NRES-1];
  assign p_out     = res_dat_q[NRES-1];
  assign ovf       = res_ovf_q[NRES-1];
  assign adv_c     = !out_valid || out_ready;
  // A sample offered during rstP would be discarded by the clear, so it is
  // refused instead of being silently lost.
  assign in_ready  = (state_q == S_RUN) && en && !flush && adv_c && !rstP;
  assign accept_c  = in_valid && in_ready;
  assign any_vld_c = s1_vld_q || (|res_vld_q);

  // Stage 1 operand conditioning
  always_comb begin
    a_eff_c = (mode == MODE_PRESHIFT) ? (a_in << PRESHIFT) : a_in;
    b_eff_c = b_in;
    if (rapx) begin
      a_eff_c = a_eff_c & APX_MASK;
      b_eff_c = b_eff_c & APX_MASK;
    end
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      s1_vld_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
    end else if (rstP) begin
      s1_vld_q  <= 1'b0;
    end else if (adv_c) begin
      s1_vld_q <= accept_c;
      if (accept_c) begin
        s1_a_q    <= a_eff_c;
        s1_b_q    <= b_eff_c;
        s1_mode_q <= mode;
      end
    end
  end

  conf_int_mul_core #(
    .DP (DP)
  ) u_core (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (prod_c)
  );

  // Window selection; the mode travels with the sample, so a mid-stream
  // mode change only affects samples accepted after it.
  always_comb begin
    prod_w_c  = WIN_W'(prod_c);
    lsb_c     = (s1_mode_q == MODE_PRESHIFT) ? LSB_PRE : LSB_DIR;
    res_dat_c = OUT_BITWIDTH'(sat_window(prod_w_c, lsb_c, K_U));
    res_ovf_c = window_ovf(prod_w_c, lsb_c, K_U);
  end

  // Stage 2 and any further delay stages. Bubbles load zeros so p_out is
  // clean while out_valid is low.
  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      res_vld_q <= '0;
      res_ovf_q <= '0;
      for (int i = 0; i < NRES; i++) res_dat_q[i] <= '0;
    end else if (rstP) begin
      res_vld_q <= '0;
      res_ovf_q <= '0;
      for (int i = 0; i < NRES; i++) res_dat_q[i] <= '0;
    end else if (adv_c) begin
      res_vld_q[0] <= s1_vld_q;
      res_ovf_q[0] <= s1_vld_q && res_ovf_c;
      res_dat_q[0] <= s1_vld_q ? res_dat_c : '0;
      for (int i = 1; i < NRES; i++) begin
        res_vld_q[i] <= res_vld_q[i-1];
        res_ovf_q[i] <= res_ovf_q[i-1];
        res_dat_q[i] <= res_dat_q[i-1];
      end
    end
  end

  // Control FSM
  always_comb begin
    state_d      = state_q;
    flush_done_c = 1'b0;
    case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (flush || !en) state_d = S_FLUSH;
      S_FLUSH: begin
        if (!any_vld_c) begin
          state_d      = S_IDLE;
          flush_done_c = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign flush_done = flush_done_c && !rstP;

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      state_q <= S_IDLE;
    end else if (rstP) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample counter; accepts never coincide with flush_done (state is FLUSH).
  always_comb begin
    cnt_d = cnt_q;
    if (flush_done_c) begin
      cnt_d = '0;
    end else if (accept_c) begin
      cnt_d = cnt_q + CNT_BITWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge racc) begin
    if (racc) begin
      cnt_q <= '0;
    end else if (rstP) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_conf_int_mul_pipe_wrapper.sv
// Purpose : self-checking bench for conf_int_mul_pipe_wrapper (default parameters, DP=24, OUT=32).
// Latency : checks PIPE_STAGES=2 accept-to-valid latency on isolated samples.
// Backpr. : exercises an output stall mid-stream and checks in_ready/p_out hold.
module tb_conf_int_mul_pipe_wrapper;

  logic        clk = 1'b0;
  logic        racc, rstP, rapx, en, flush;
  logic        in_valid, in_ready, mode;
  logic [23:0] a_in, b_in;
  logic        out_valid, out_ready, ovf, flush_done;
  logic [31:0] p_out;
  logic [8:0]  sample_cnt;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  typedef struct packed {
    logic [31:0] p;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  conf_int_mul_pipe_wrapper dut (
    .clk        (clk),
    .racc       (racc),
    .rstP       (rstP),
    .rapx       (rapx),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p_out      (p_out),
    .ovf        (ovf),
    .flush_done (flush_done),
    .sample_cnt (sample_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: full-precision signed product, shift down to the
  // window LSB, clamp to 29 signed bits (32 outputs minus 3 guard bits).
  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic m, input logic r);
    logic [23:0] ae, be;
    longint      sa, sb, pr, sh;
    exp_t        e;
    ae = m ? {a[15:0], 8'h00} : a;
    be = b;
    if (r) begin
      ae[7:0] = 8'h00;
      be[7:0] = 8'h00;
    end
    sa = longint'($signed(ae));
    sb = longint'($signed(be));
    pr = sa * sb;
    sh = pr >>> (m ? 19 : 11);
    if (sh > 64'sd268435455) begin
      e.p = 32'h0FFF_FFFF; e.ovf = 1'b1;
    end else if (sh < -64'sd268435456) begin
      e.p = 32'hF000_0000; e.ovf = 1'b1;
    end else begin
      e.p = sh[31:0]; e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Compare process: every output transfer is checked against the model
  // queue; every accepted input pushes its expected result.
  always @(negedge clk) begin
    if (racc || rstP) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("out_has_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("model_p_out", p_out, mon_e.p);
          check("model_ovf", ovf, mon_e.ovf);
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a_in, b_in, mode, rapx));
    end
  end

  task automatic send(input logic [23:0] a, input logic [23:0] b, input logic m, input logic r);
    int   t;
    logic rdy;
    a_in = a; b_in = b; mode = m; rapx = r; in_valid = 1'b1;
    t = 0; rdy = 1'b0;
    while (!rdy && t < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    check("send_accepted", rdy, 1);
  endtask

  task automatic send_expect(input string name, input logic [23:0] a, input logic [23:0] b,
                             input logic m, input logic r,
                             input logic [31:0] exp_p, input logic exp_ovf);
    int lat;
    send(a, b, m, r);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 2);
    check({name, "_p_out"}, p_out, exp_p);
    check({name, "_ovf"}, ovf, exp_ovf);
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input string name, input int exp_outs);
    int   t, n0;
    logic seen;
    n0 = n_out; t = 0; seen = 1'b0;
    flush = 1'b1;
    while (!seen && t < 50) begin
      @(negedge clk);
      seen = flush_done;
      t++;
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_outs"}, n_out - n0, exp_outs);
    flush = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_pulse_1cyc"}, flush_done, 0);
    check({name, "_cnt_clear"}, sample_cnt, 0);
  endtask

  initial begin
    logic [31:0] held;
    int          t, n0;
    racc = 1'b1; rstP = 1'b0; rapx = 1'b0; en = 1'b0; flush = 1'b0;
    in_valid = 1'b0; a_in = '0; b_in = '0; mode = 1'b0; out_ready = 1'b1;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_p_out", p_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_sample_cnt", sample_cnt, 0);
    check("rst_in_ready", in_ready, 0);

    @(posedge clk); #1;
    racc = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results
    send_expect("direct",      24'h000300, 24'h000400, 1'b0, 1'b0, 32'h0000_0180, 1'b0);
    send_expect("preshift",    24'h000300, 24'h000400, 1'b1, 1'b0, 32'h0000_0180, 1'b0);
    send_expect("direct_b4ff", 24'h000300, 24'h0004FF, 1'b0, 1'b0, 32'h0000_01DF, 1'b0);
    send_expect("rapx_pos",    24'h000300, 24'h0004FF, 1'b0, 1'b1, 32'h0000_0180, 1'b0);
    send_expect("rapx_neg",    24'hFFFD00, 24'h000400, 1'b0, 1'b1, 32'hFFFF_FE80, 1'b0);
    send_expect("sat_pos",     24'h7FFFFF, 24'h7FFFFF, 1'b0, 1'b0, 32'h0FFF_FFFF, 1'b1);
    send_expect("sat_neg",     24'h800000, 24'h7FFFFF, 1'b0, 1'b0, 32'hF000_0000, 1'b1);
    send_expect("preshift_trunc", 24'h800300, 24'h000400, 1'b1, 1'b0, 32'h0000_0180, 1'b0);
    check("cnt_after_directed", sample_cnt, 8);

    do_flush("flush_empty", 0);

    // Back-pressure: 10-sample stream with a 5-cycle output stall
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(24'(32'h100 * (i + 1)), 24'h000800 + 24'(i), i[0], i == 7);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = p_out;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          check("stall_p_out_hold", p_out, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    t = 0;
    while (n_out - n0 < 10 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("stream_outputs", n_out - n0, 10);
    check("stream_cnt", sample_cnt, 10);

    // Flush with two samples in flight: both must come out before the pulse
    do_flush("flush_two", 0);
    @(posedge clk); #1;
    send(24'h000300, 24'h000400, 1'b0, 1'b0);
    send(24'hFFFD00, 24'h000400, 1'b0, 1'b0);
    do_flush("flush_inflight", 2);

    // Synchronous clear with a sample in stage 1
    @(posedge clk); #1;
    send(24'h000300, 24'h000400, 1'b0, 1'b0);
    rstP = 1'b1;
    @(posedge clk); #1;
    rstP = 1'b0;
    check("rstp_out_valid", out_valid, 0);
    check("rstp_p_out", p_out, 0);
    check("rstp_cnt", sample_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rstp_no_late_out", out_valid, 0);

    // Asynchronous reset with two samples in flight
    send(24'h000300, 24'h000400, 1'b0, 1'b0);
    send(24'h000300, 24'h0004FF, 1'b0, 1'b0);
    check("pre_racc_out_valid", out_valid, 1);
    racc = 1'b1;
    #1;
    check("racc_out_valid", out_valid, 0);
    check("racc_p_out", p_out, 0);
    check("racc_cnt", sample_cnt, 0);
    check("racc_in_ready", in_ready, 0);
    @(posedge clk); #1;
    racc = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
